// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// State encodings, grant IDs and LATENCY limits.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_t;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU fetch/data ports and memory bus of the port arbiter.
// slave = arbiter side, master = CPU/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata,
    output if_rdata, if_valid,
    output d_rdata, d_valid,
    output mem_en, mem_we,
    output mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata,
    input  if_rdata, if_valid,
    input  d_rdata, d_valid,
    input  mem_en, mem_we,
    input  mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational grant pick for the port arbiter.
// ARB_FAIR_EN selects round-robin; otherwise data wins ties.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic mask_if,
  input  logic mask_d,
`ifdef ARB_FAIR_EN
  input  gnt_t last_gnt,
`endif
  output logic any,
  output gnt_t gnt
);

  logic r_if;
  logic r_d;

  assign r_if = if_req & ~mask_if;
  assign r_d  = d_req & ~mask_d;
  assign any  = r_if | r_d;

  always_comb begin
    gnt = GNT_IF;
    unique case (1'b1)
      r_d && !r_if: gnt = GNT_D;
      r_if && !r_d: gnt = GNT_IF;
      r_d && r_if: begin
`ifdef ARB_FAIR_EN
        gnt = (last_gnt == GNT_IF) ? GNT_D : GNT_IF;
`else
        gnt = GNT_D;
`endif
      end
      default: gnt = GNT_IF;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-ported fixed-latency memory.
// Define ARB_FAIR_EN for round-robin instead of data priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic               clock,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus,
  output logic               busy
);

  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  state_t            state_q, state_d;
  gnt_t              gnt_q, gnt_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] ird_q, ird_d;
  logic [DATA_W-1:0] drd_q, drd_d;
  logic              ifv_q, ifv_d;
  logic              dv_q, dv_d;
  logic              busy_q, busy_d;
  logic              take;
  logic              pick_any;
  gnt_t              pick_gnt;
  logic              mask_if;
  logic              mask_d;
`ifdef ARB_FAIR_EN
  gnt_t              last_q, last_d;
`endif

  // the port served in DONE still holds req this cycle
  assign mask_if = (state_q == S_DONE) && (gnt_q == GNT_IF);
  assign mask_d  = (state_q == S_DONE) && (gnt_q == GNT_D);

  mem_arb_pick u_pick (
    .if_req   (bus.if_req),
    .d_req    (bus.d_req),
    .mask_if  (mask_if),
    .mask_d   (mask_d),
`ifdef ARB_FAIR_EN
    .last_gnt (last_q),
`endif
    .any      (pick_any),
    .gnt      (pick_gnt)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ird_d   = ird_q;
    drd_d   = drd_q;
    take    = 1'b0;
`ifdef ARB_FAIR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      S_IDLE: take = pick_any;
      S_ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = S_DONE;
          if (gnt_q == GNT_IF) begin
            ird_d = bus.mem_rdata;
          end else if (!we_q) begin
            drd_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_DONE: begin
        take    = pick_any;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (take) begin
      state_d = S_ISSUE;
      gnt_d   = pick_gnt;
`ifdef ARB_FAIR_EN
      last_d  = pick_gnt;
`endif
      if (pick_gnt == GNT_D) begin
        we_d    = bus.d_we;
        addr_d  = bus.d_addr;
        wdata_d = bus.d_wdata;
      end else begin
        we_d    = 1'b0;
        addr_d  = bus.if_addr;
      end
    end
    en_d   = (state_d == S_ISSUE);
    busy_d = (state_d != S_IDLE);
    ifv_d  = (state_d == S_DONE) && (gnt_d == GNT_IF);
    dv_d   = (state_d == S_DONE) && (gnt_d == GNT_D);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      gnt_q   <= GNT_IF;
      cnt_q   <= 3'd0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ird_q   <= '0;
      drd_q   <= '0;
      ifv_q   <= 1'b0;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef ARB_FAIR_EN
      last_q  <= GNT_IF;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ird_q   <= ird_d;
      drd_q   <= drd_d;
      ifv_q   <= ifv_d;
      dv_q    <= dv_d;
      busy_q  <= busy_d;
`ifdef ARB_FAIR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign bus.mem_en    = en_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = ird_q;
  assign bus.if_valid  = ifv_q;
  assign bus.d_rdata   = drd_q;
  assign bus.d_valid   = dv_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one DUT per LATENCY 1..8,
// scoreboard of expected accesses and completions.
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cur   = 1;
  int n_en  = 0;
  int n_valid = 0;
  int n_if_en = 0;
  logic drop_if = 1'b0;
  logic drop_d  = 1'b0;

  logic [8:1]  if_req_a, d_req_a, d_we_a;
  logic [31:0] if_addr_a [1:8];
  logic [31:0] d_addr_a  [1:8];
  logic [31:0] d_wdata_a [1:8];
  logic [8:1]  if_valid_v, d_valid_v, en_v, mwe_v, busy_v;
  logic [31:0] if_rdata_a [1:8];
  logic [31:0] d_rdata_a  [1:8];
  logic [31:0] maddr_a    [1:8];
  logic [31:0] mwdata_a   [1:8];
  logic [31:0] exp_ird [1:8];
  logic [31:0] exp_drd [1:8];

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } vexp_t;

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } aexp_t;

  vexp_t q_if[$];
  vexp_t q_d[$];
  aexp_t q_aif[$];
  aexp_t q_ad[$];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  for (genvar g = 1; g <= 8; g++) begin : g_dut
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    logic [31:0] pipe [g];

    assign bus.if_req  = if_req_a[g];
    assign bus.if_addr = if_addr_a[g];
    assign bus.d_req   = d_req_a[g];
    assign bus.d_we    = d_we_a[g];
    assign bus.d_addr  = d_addr_a[g];
    assign bus.d_wdata = d_wdata_a[g];
    assign bus.mem_rdata = pipe[g-1];
    assign if_valid_v[g] = bus.if_valid;
    assign d_valid_v[g]  = bus.d_valid;
    assign en_v[g]       = bus.mem_en;
    assign mwe_v[g]      = bus.mem_we;
    assign if_rdata_a[g] = bus.if_rdata;
    assign d_rdata_a[g]  = bus.d_rdata;
    assign maddr_a[g]    = bus.mem_addr;
    assign mwdata_a[g]   = bus.mem_wdata;

    // read data is only meaningful exactly g cycles after mem_en
    always @(posedge clock) begin
      pipe[0] <= bus.mem_en ? memfn(bus.mem_addr) : 32'hBAD0BAD0;
      for (int k = 1; k < g; k++) pipe[k] <= pipe[k-1];
    end

    mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .LATENCY(g)
    ) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus),
      .busy  (busy_v[g])
    );
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s L=%0d cyc=%0d obs=%0h exp=%0h",
             tag, cur, cyc, obs, exp);
    end
  endtask

  function automatic int at(input int off);
    return (off < 0) ? -1 : cyc + off;
  endfunction

  task automatic step();
    vexp_t v;
    aexp_t a;
    @(negedge clock);
    cyc++;
    if (drop_if) begin if_req_a[cur] = 1'b0; drop_if = 1'b0; end
    if (drop_d)  begin d_req_a[cur]  = 1'b0; drop_d  = 1'b0; end
    chk("excl_valid", if_valid_v[cur] & d_valid_v[cur], 0);
    if (en_v[cur]) begin
      n_en++;
      chk("busy_at_en", busy_v[cur], 1);
      if (maddr_a[cur][12]) begin
        chk("d_en_pending", q_ad.size() != 0, 1);
        if (q_ad.size() != 0) begin
          a = q_ad.pop_front();
          if (a.cyc >= 0) chk("d_en_cyc", cyc, a.cyc);
          chk("d_mem_we", mwe_v[cur], a.we);
          chk("d_mem_addr", maddr_a[cur], a.addr);
          if (a.we) chk("d_mem_wdata", mwdata_a[cur], a.wdata);
        end
      end else begin
        n_if_en++;
        chk("if_en_pending", q_aif.size() != 0, 1);
        if (q_aif.size() != 0) begin
          a = q_aif.pop_front();
          if (a.cyc >= 0) chk("if_en_cyc", cyc, a.cyc);
          chk("if_mem_we", mwe_v[cur], 0);
          chk("if_mem_addr", maddr_a[cur], a.addr);
        end
      end
    end
    if (if_valid_v[cur]) begin
      n_valid++;
      drop_if = 1'b1;
      chk("if_valid_pending", q_if.size() != 0, 1);
      if (q_if.size() != 0) begin
        v = q_if.pop_front();
        if (v.cyc >= 0) chk("if_valid_cyc", cyc, v.cyc);
        chk("if_rdata", if_rdata_a[cur], v.data);
      end
    end
    if (d_valid_v[cur]) begin
      n_valid++;
      drop_d = 1'b1;
      chk("d_valid_pending", q_d.size() != 0, 1);
      if (q_d.size() != 0) begin
        v = q_d.pop_front();
        if (v.cyc >= 0) chk("d_valid_cyc", cyc, v.cyc);
        chk("d_rdata", d_rdata_a[cur], v.data);
      end
    end
  endtask

  task automatic go_if(input logic [31:0] addr,
                       input int eoff, input int voff);
    if_req_a[cur]  = 1'b1;
    if_addr_a[cur] = addr;
    exp_ird[cur]   = memfn(addr);
    q_aif.push_back('{at(eoff), 1'b0, addr, 32'h0});
    q_if.push_back('{at(voff), memfn(addr)});
  endtask

  task automatic go_d(input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata,
                      input int eoff, input int voff);
    d_req_a[cur]   = 1'b1;
    d_we_a[cur]    = we;
    d_addr_a[cur]  = addr;
    d_wdata_a[cur] = wdata;
    if (!we) exp_drd[cur] = memfn(addr);
    q_ad.push_back('{at(eoff), we, addr, wdata});
    q_d.push_back('{at(voff), exp_drd[cur]});
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((q_if.size() != 0 || q_d.size() != 0 ||
            q_aif.size() != 0 || q_ad.size() != 0 ||
            if_req_a[cur] || d_req_a[cur]) && n < maxc) begin
      step();
      n++;
    end
    chk("wait_in_budget", n < maxc, 1);
    if (n >= maxc) begin
      q_if.delete(); q_d.delete(); q_aif.delete(); q_ad.delete();
      if_req_a[cur] = 1'b0;
      d_req_a[cur]  = 1'b0;
    end
    chk("idle_busy", busy_v[cur], 0);
    chk("if_rdata_hold", if_rdata_a[cur], exp_ird[cur]);
    chk("d_rdata_hold", d_rdata_a[cur], exp_drd[cur]);
  endtask

  initial begin
    int n0;
    logic seen;
    reset    = 1'b0;
    if_req_a = '0;
    d_req_a  = '0;
    d_we_a   = '0;
    for (int i = 1; i <= 8; i++) begin
      if_addr_a[i] = '0; d_addr_a[i] = '0; d_wdata_a[i] = '0;
      exp_ird[i] = '0; exp_drd[i] = '0;
    end
    repeat (3) step();
    for (int i = 1; i <= 8; i++) begin
      cur = i;
      chk("rst_busy", busy_v[i], 0);
      chk("rst_en", en_v[i], 0);
      chk("rst_we", mwe_v[i], 0);
      chk("rst_valid", {if_valid_v[i], d_valid_v[i]}, 0);
      chk("rst_addr", maddr_a[i], 0);
      chk("rst_rdata", {if_rdata_a[i], d_rdata_a[i]}, 0);
    end
    reset = 1'b1;
    cur = 1;
    step();

    // fetch only, LATENCY=1
    cur = 1;
    go_if(32'h40, 1, 3);
    wait_idle(20);

    // store / load / store, LATENCY=3
    cur = 3;
    go_d(1'b1, 32'h1100, 32'h12345678, 1, 5);
    wait_idle(20);
    go_d(1'b0, 32'h1104, 32'h0, 1, 5);
    wait_idle(20);
    go_d(1'b1, 32'h1108, 32'hCAFEF00D, 1, 5);
    wait_idle(20);

    // simultaneous requests, LATENCY=2: data first
    cur = 2;
    go_d(1'b0, 32'h1200, 32'h0, 1, 4);
    go_if(32'h80, 5, 8);
    wait_idle(30);
    go_d(1'b0, 32'h1204, 32'h0, 1, 4);
    wait_idle(20);
`ifdef ARB_FAIR_EN
    go_if(32'h84, 1, 4);
    go_d(1'b0, 32'h1208, 32'h0, 5, 8);
`else
    go_d(1'b0, 32'h1208, 32'h0, 1, 4);
    go_if(32'h84, 5, 8);
`endif
    wait_idle(30);

    // data re-requests continuously; DONE hands off to waiting fetch
    cur = 1;
    n0 = n_if_en;
    go_if(32'h48, -1, -1);
    go_d(1'b0, 32'h1300, 32'h0, -1, -1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (!d_req_a[cur] && seen) begin
        go_d(1'b0, 32'h1300 + 32'(4 * i), 32'h0, -1, -1);
        seen = 1'b0;
      end else begin
        seen = !d_req_a[cur];
      end
    end
    chk("if_grants_in_window", n_if_en - n0, 1);
    wait_idle(60);

    // latency sweep
    for (int l = 1; l <= 8; l++) begin
      cur = l;
      go_if(32'h200 + 32'(4 * l), 1, l + 2);
      wait_idle(30);
      go_d(1'b0, 32'h1400 + 32'(4 * l), 32'h0, 1, l + 2);
      wait_idle(30);
      go_d(1'b1, 32'h1500 + 32'(4 * l),
           32'h11111111 * 32'(l), 1, l + 2);
      wait_idle(30);
    end
    chk("en_vs_valid", n_en, n_valid);

    // reset during WAIT, LATENCY=3
    cur = 3;
    go_if(32'h300, 1, 5);
    step();
    step();
    reset = 1'b0;
    if_req_a[cur] = 1'b0;
    step();
    chk("rst_wait_busy", busy_v[cur], 0);
    chk("rst_wait_en_we", {en_v[cur], mwe_v[cur]}, 0);
    chk("rst_wait_valid", {if_valid_v[cur], d_valid_v[cur]}, 0);
    chk("rst_wait_addr", maddr_a[cur], 0);
    chk("rst_wait_wdata", mwdata_a[cur], 0);
    chk("rst_wait_if_rdata", if_rdata_a[cur], 0);
    chk("rst_wait_d_rdata", d_rdata_a[cur], 0);
    q_if.delete();
    exp_ird[cur] = '0;
    exp_drd[cur] = '0;
    reset = 1'b1;
    repeat (8) step();
    chk("rst_abandon_idle", busy_v[cur], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
